// File: rtl/bp_pkg.sv
// Shared types for the branch predictor table: 2-bit counter encoding,
// controller states and the saturating counter transition.
package bp_pkg;

  typedef enum logic [1:0] {
    SU = 2'b00,
    WU = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } pred_state_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_t;

  function automatic pred_state_t pred_next(input pred_state_t cur, input logic taken);
    pred_state_t nxt;
    nxt = cur;
    case (cur)
      SU: nxt = taken ? WU : SU;
      WU: nxt = taken ? WT : SU;
      WT: nxt = taken ? ST : WU;
      ST: nxt = taken ? ST : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Generic up-counter that sticks at all-ones instead of wrapping.
module bp_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && (count_reg != '1)) count_next = count_reg + WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_reg <= '0;
    else         count_reg <= count_next;
  end

  assign count = count_reg;

endmodule

// File: rtl/branch_pred_table_ctrl.sv
// Direct-mapped 2-bit branch predictor table: zero-latency fetch lookup,
// one execute-stage update per cycle, clear sweep and mispredict counter.
module branch_pred_table_ctrl
  import bp_pkg::*;
#(
  parameter int          INDEX_WIDTH = 6,
  parameter pred_state_t INIT_STATE  = WU,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_table_i,
  input  logic [31:0]          pc_f_i,
  output logic                 pc_src_pred_f_o,
  input  logic [31:0]          pc_e_i,
  input  logic                 branch_e_i,
  input  logic                 stall_e_i,
  input  logic                 pc_src_res_e_i,
  input  logic                 pc_src_pred_e_i,
  output logic                 ready_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

  localparam int ENTRIES = 2 ** INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

  pred_state_t            pred_table [ENTRIES];
  ctrl_state_t            state_reg;
  logic [INDEX_WIDTH-1:0] sweep_idx_reg;
  logic                   ready_reg;

  logic [INDEX_WIDTH-1:0] idx_f;
  logic [INDEX_WIDTH-1:0] idx_e;
  logic [INDEX_WIDTH-1:0] wr_idx;
  pred_state_t            wr_data;
  pred_state_t            cur_e;
  logic                   wr_en;
  logic                   upd;
  logic                   mispredict;
  logic                   unused_pc_bits;

  assign idx_f = pc_f_i[INDEX_WIDTH+1:2];
  assign idx_e = pc_e_i[INDEX_WIDTH+1:2];
  assign unused_pc_bits = ^{pc_f_i[31:INDEX_WIDTH+2], pc_f_i[1:0],
                            pc_e_i[31:INDEX_WIDTH+2], pc_e_i[1:0]};

  // A flush in the same cycle wins over any execute update.
  assign upd        = (state_reg == RUN) & branch_e_i & ~stall_e_i & ~flush_table_i;
  assign mispredict = upd & (pc_src_res_e_i != pc_src_pred_e_i);
  assign cur_e      = pred_table[idx_e];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sweep_idx_reg;
    wr_data = INIT_STATE;
    if (state_reg == CLEAR) begin
      wr_en = 1'b1;
    end else if (upd) begin
      wr_en   = 1'b1;
      wr_idx  = idx_e;
      wr_data = pred_next(cur_e, pc_src_res_e_i);
    end
  end

  // Storage is deliberately unreset; the sweep is what makes it valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) pred_table[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= CLEAR;
      sweep_idx_reg <= '0;
      ready_reg     <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (flush_table_i) begin
            sweep_idx_reg <= '0;
          end else begin
            sweep_idx_reg <= sweep_idx_reg + INDEX_WIDTH'(1);
            if (sweep_idx_reg == LAST_IDX) begin
              state_reg <= RUN;
              ready_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (flush_table_i) begin
            state_reg     <= CLEAR;
            sweep_idx_reg <= '0;
            ready_reg     <= 1'b0;
          end
        end
        default: begin
          state_reg     <= CLEAR;
          sweep_idx_reg <= '0;
          ready_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Lookup returns the stored value; a same-cycle update shows up next cycle.
  assign pc_src_pred_f_o = ready_reg & pred_table[idx_f][1];
  assign ready_o         = ready_reg;

  bp_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_mispredict_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .inc    (mispredict),
    .count  (mispredict_cnt_o)
  );

endmodule
